imem_fetch_ctrl: RTL and testbench

Instruction-fetch controller that sequences the combinational instruction memory (byte address in, 32-bit word out, same cycle). It owns the fetch PC, issues one fetch per cycle into a small prefetch FIFO, and presents fetched words to the decode stage over a valid/ready handshake. It handles branch/jump redirects with a full flush, plus a halt request from the core.

---
 rtl/imem_fetch_ctrl.sv | 115 +++++++++++
 tb/tb_imem_fetch_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : imem_fetch_ctrl
// Description : Instruction-fetch controller. Owns the fetch PC, fetches one
//               word per cycle into a prefetch FIFO and hands words to decode
//               over valid/ready. Supports redirect flush and halt.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_fetch_ctrl #(
   parameter int          DEPTH    = 2,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                     CLK,
   input  logic                     RST,
   output logic [31:0]              IMEM_ADDR,
   input  logic [31:0]              IMEM_INST,
   output logic                     IF_VALID,
   input  logic                     IF_READY,
   output logic [31:0]              IF_INST,
   output logic [31:0]              IF_PC,
   input  logic                     REDIRECT,
   input  logic [31:0]              REDIRECT_PC,
   input  logic                     HALT,
   output logic [$clog2(DEPTH):0]   FIFO_LVL,
   output logic [31:0]              FETCH_CNT
);

   localparam int             AW       = $clog2(DEPTH);
   localparam int             LW       = AW + 1;
   localparam logic [LW-1:0]  FULL_LVL = LW'(DEPTH);

   logic [31:0]   pc_q,  pc_d;
   logic [31:0]   cnt_q, cnt_d;
   logic [LW-1:0] lvl_q, lvl_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [31:0]   pc_mem_q   [DEPTH];
   logic [31:0]   pc_mem_d   [DEPTH];
   logic [31:0]   inst_mem_q [DEPTH];
   logic [31:0]   inst_mem_d [DEPTH];

   logic          not_empty;
   logic          pop;
   logic          push;

   assign not_empty = (lvl_q != '0);
   assign pop       = not_empty & IF_READY;
   // A pop in the same cycle frees a slot, so a full FIFO can still accept.
   assign push      = ~REDIRECT & ~HALT & ((lvl_q != FULL_LVL) | pop);

   always_comb begin
      pc_d       = pc_q;
      cnt_d      = cnt_q;
      lvl_d      = lvl_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      pc_mem_d   = pc_mem_q;
      inst_mem_d = inst_mem_q;

      if (REDIRECT) begin
         pc_d     = REDIRECT_PC & ~32'h0000_0003;
         lvl_d    = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push) begin
            pc_mem_d[wr_ptr_q]   = pc_q;
            inst_mem_d[wr_ptr_q] = IMEM_INST;
            wr_ptr_d             = wr_ptr_q + 1'b1;
            pc_d                 = pc_q + 32'd4;
            cnt_d                = cnt_q + 32'd1;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         if (push && !pop) begin
            lvl_d = lvl_q + 1'b1;
         end else if (pop && !push) begin
            lvl_d = lvl_q - 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         pc_q     <= RESET_PC;
         cnt_q    <= '0;
         lvl_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem_q[i]   <= '0;
            inst_mem_q[i] <= '0;
         end
      end else begin
         pc_q       <= pc_d;
         cnt_q      <= cnt_d;
         lvl_q      <= lvl_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         pc_mem_q   <= pc_mem_d;
         inst_mem_q <= inst_mem_d;
      end
   end

   // Head is driven from storage only; an empty FIFO presents zeros.
   assign IMEM_ADDR = pc_q;
   assign IF_VALID  = not_empty;
   assign IF_PC     = not_empty ? pc_mem_q[rd_ptr_q]   : 32'h0;
   assign IF_INST   = not_empty ? inst_mem_q[rd_ptr_q] : 32'h0;
   assign FIFO_LVL  = lvl_q;
   assign FETCH_CNT = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_fetch_ctrl
// Description : Self-checking bench for imem_fetch_ctrl using a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_fetch_ctrl;

   localparam int DEPTH = 2;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic [31:0]   imem_addr;
   logic [31:0]   imem_inst;
   logic          if_valid;
   logic          if_ready;
   logic [31:0]   if_inst;
   logic [31:0]   if_pc;
   logic          redirect;
   logic [31:0]   redirect_pc;
   logic          halt;
   logic [LW-1:0] fifo_lvl;
   logic [31:0]   fetch_cnt;

   int            n_tests = 0;
   int            n_fail  = 0;

   logic [63:0]   mq [$];
   logic [31:0]   m_pc;
   logic [31:0]   m_cnt;

   imem_fetch_ctrl #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
      .CLK         (clk),
      .RST         (rst),
      .IMEM_ADDR   (imem_addr),
      .IMEM_INST   (imem_inst),
      .IF_VALID    (if_valid),
      .IF_READY    (if_ready),
      .IF_INST     (if_inst),
      .IF_PC       (if_pc),
      .REDIRECT    (redirect),
      .REDIRECT_PC (redirect_pc),
      .HALT        (halt),
      .FIFO_LVL    (fifo_lvl),
      .FETCH_CNT   (fetch_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] imem_word(input logic [31:0] a);
      case (a)
         32'h0000_0000: return 32'h0000_0013;
         32'h0000_0044: return 32'h03cf_5863;
         32'h0000_0100: return 32'h0000_0000;
         default:       return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
      endcase
   endfunction

   assign imem_inst = imem_word(imem_addr);

   task automatic model_reset();
      mq.delete();
      m_pc  = 32'h0;
      m_cnt = 32'h0;
   endtask

   // Drive one cycle at the falling edge, advance the model, return at the next falling edge.
   task automatic cycle(input logic rdy, input logic rd, input logic [31:0] rpc, input logic hlt);
      logic p_pop;
      logic p_push;
      if_ready    = rdy;
      redirect    = rd;
      redirect_pc = rpc;
      halt        = hlt;
      p_pop  = (mq.size() != 0) && rdy;
      p_push = !rd && !hlt && ((mq.size() < DEPTH) || p_pop);
      if (rd) begin
         mq.delete();
         m_pc = rpc & ~32'h3;
      end else begin
         if (p_pop) void'(mq.pop_front());
         if (p_push) begin
            mq.push_back({m_pc, imem_word(m_pc)});
            m_pc  = m_pc + 32'd4;
            m_cnt = m_cnt + 32'd1;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; if_ready = 1'b1; redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
      model_reset();
      repeat (3) begin
         @(negedge clk);
         n_tests++;
         if (imem_addr !== 32'h0 || if_valid !== 1'b0 || fifo_lvl !== '0 ||
             fetch_cnt !== 32'h0 || if_pc !== 32'h0 || if_inst !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state: addr=%h valid=%b lvl=%0d cnt=%0d pc=%h inst=%h, required all zero",
                     imem_addr, if_valid, fifo_lvl, fetch_cnt, if_pc, if_inst);
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_startup();
      for (int k = 1; k <= 6; k++) begin
         cycle(1'b1, 1'b0, 32'h0, 1'b0);
         n_tests++;
         if (if_valid !== 1'b1 || if_pc !== 32'(4 * (k - 1)) || fetch_cnt !== 32'(k)) begin
            n_fail++;
            $display("FAIL startup_step%0d: valid=%b pc=%h cnt=%0d, required 1 %h %0d",
                     k, if_valid, if_pc, fetch_cnt, 32'(4 * (k - 1)), k);
         end
         if (k == 1) begin
            n_tests++;
            if (if_inst !== 32'h0000_0013) begin
               n_fail++;
               $display("FAIL startup_inst: got %h required 00000013", if_inst);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      repeat (6) cycle(1'b0, 1'b0, 32'h0, 1'b0);
      n_tests++;
      if (fifo_lvl !== LW'(2) || imem_addr !== 32'h1C || if_pc !== 32'h14) begin
         n_fail++;
         $display("FAIL backpressure_hold: lvl=%0d addr=%h pc=%h, required 2 0000001c 00000014",
                  fifo_lvl, imem_addr, if_pc);
      end
      for (int k = 0; k < 3; k++) begin
         n_tests++;
         if (if_valid !== 1'b1 || if_pc !== 32'(32'h14 + 4 * k)) begin
            n_fail++;
            $display("FAIL backpressure_drain%0d: valid=%b pc=%h, required 1 %h",
                     k, if_valid, if_pc, 32'(32'h14 + 4 * k));
         end
         cycle(1'b1, 1'b0, 32'h0, 1'b0);
      end
   endtask

   task automatic test_redirect_full();
      int guard = 0;
      while (m_pc != 32'h7C && guard < 64) begin
         cycle(1'b1, 1'b0, 32'h0, 1'b0);
         guard++;
      end
      n_tests++;
      if (imem_addr !== 32'h7C) begin
         n_fail++;
         $display("FAIL redirect_setup: addr=%h required 0000007c", imem_addr);
      end
      cycle(1'b0, 1'b0, 32'h0, 1'b0);
      cycle(1'b0, 1'b1, 32'h47, 1'b0);
      n_tests++;
      if (fifo_lvl !== '0 || if_valid !== 1'b0 || imem_addr !== 32'h44) begin
         n_fail++;
         $display("FAIL redirect_flush: lvl=%0d valid=%b addr=%h, required 0 0 00000044",
                  fifo_lvl, if_valid, imem_addr);
      end
      cycle(1'b0, 1'b0, 32'h0, 1'b0);
      n_tests++;
      if (if_valid !== 1'b1 || if_pc !== 32'h44 || if_inst !== 32'h03cf_5863) begin
         n_fail++;
         $display("FAIL redirect_first: valid=%b pc=%h inst=%h, required 1 00000044 03cf5863",
                  if_valid, if_pc, if_inst);
      end
   endtask

   task automatic test_push_pop_full();
      logic [31:0] cnt_before;
      cycle(1'b0, 1'b0, 32'h0, 1'b0);
      cnt_before = m_cnt;
      cycle(1'b1, 1'b0, 32'h0, 1'b0);
      n_tests++;
      if (fifo_lvl !== LW'(2) || if_pc !== 32'h48 || fetch_cnt !== cnt_before + 32'd1) begin
         n_fail++;
         $display("FAIL push_pop_full: lvl=%0d pc=%h cnt=%0d, required 2 00000048 %0d",
                  fifo_lvl, if_pc, fetch_cnt, cnt_before + 32'd1);
      end
   endtask

   task automatic test_halt_drain();
      cycle(1'b1, 1'b0, 32'h0, 1'b1);
      n_tests++;
      if (if_valid !== 1'b1 || if_pc !== 32'h4C || fifo_lvl !== LW'(1)) begin
         n_fail++;
         $display("FAIL halt_drain1: valid=%b pc=%h lvl=%0d, required 1 0000004c 1",
                  if_valid, if_pc, fifo_lvl);
      end
      cycle(1'b1, 1'b0, 32'h0, 1'b1);
      cycle(1'b1, 1'b0, 32'h0, 1'b1);
      n_tests++;
      if (if_valid !== 1'b0 || imem_addr !== 32'h50) begin
         n_fail++;
         $display("FAIL halt_frozen: valid=%b addr=%h, required 0 00000050", if_valid, imem_addr);
      end
      cycle(1'b0, 1'b0, 32'h0, 1'b0);
      n_tests++;
      if (if_valid !== 1'b1 || if_pc !== 32'h50 || imem_addr !== 32'h54) begin
         n_fail++;
         $display("FAIL halt_resume: valid=%b pc=%h addr=%h, required 1 00000050 00000054",
                  if_valid, if_pc, imem_addr);
      end
      cycle(1'b0, 1'b1, 32'h203, 1'b1);
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
      n_tests++;
      if (if_valid !== 1'b0 || fifo_lvl !== '0 || imem_addr !== 32'h200) begin
         n_fail++;
         $display("FAIL halt_redirect: valid=%b lvl=%0d addr=%h, required 0 0 00000200",
                  if_valid, fifo_lvl, imem_addr);
      end
      cycle(1'b0, 1'b0, 32'h0, 1'b0);
      n_tests++;
      if (if_valid !== 1'b1 || if_pc !== 32'h200) begin
         n_fail++;
         $display("FAIL halt_redirect_resume: valid=%b pc=%h, required 1 00000200", if_valid, if_pc);
      end
   endtask

   task automatic test_random();
      logic [63:0] h;
      logic [31:0] rpc;
      for (int i = 0; i < 400; i++) begin
         rpc = ($urandom_range(0, 3) == 0) ? 32'h100 : $urandom;
         cycle($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, rpc, $urandom_range(0, 9) == 0);
         n_tests++;
         if (imem_addr !== m_pc || if_valid !== (mq.size() != 0) ||
             fifo_lvl !== LW'(mq.size()) || fetch_cnt !== m_cnt) begin
            n_fail++;
            $display("FAIL random_ctrl%0d: addr=%h valid=%b lvl=%0d cnt=%0d, required %h %b %0d %0d",
                     i, imem_addr, if_valid, fifo_lvl, fetch_cnt, m_pc, mq.size() != 0,
                     mq.size(), m_cnt);
         end
         if (mq.size() != 0) begin
            h = mq[0];
            n_tests++;
            if (if_pc !== h[63:32] || if_inst !== h[31:0]) begin
               n_fail++;
               $display("FAIL random_head%0d: pc=%h inst=%h, required %h %h",
                        i, if_pc, if_inst, h[63:32], h[31:0]);
            end
         end
      end
   endtask

   task automatic test_async_reset();
      cycle(1'b1, 1'b1, 32'h58, 1'b0);
      cycle(1'b1, 1'b0, 32'h0, 1'b0);
      cycle(1'b1, 1'b0, 32'h0, 1'b0);
      n_tests++;
      if (imem_addr !== 32'h60 || if_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL async_setup: addr=%h valid=%b, required 00000060 1", imem_addr, if_valid);
      end
      #2 rst = 1'b1;
      #1;
      n_tests++;
      if (if_valid !== 1'b0 || fifo_lvl !== '0 || fetch_cnt !== 32'h0 || imem_addr !== 32'h0) begin
         n_fail++;
         $display("FAIL async_reset: valid=%b lvl=%0d cnt=%0d addr=%h, required 0 0 0 00000000",
                  if_valid, fifo_lvl, fetch_cnt, imem_addr);
      end
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      cycle(1'b1, 1'b0, 32'h0, 1'b0);
      n_tests++;
      if (if_valid !== 1'b1 || if_pc !== 32'h0 || fetch_cnt !== 32'd1) begin
         n_fail++;
         $display("FAIL async_restart: valid=%b pc=%h cnt=%0d, required 1 00000000 1",
                  if_valid, if_pc, fetch_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_startup();
      test_backpressure();
      test_redirect_full();
      test_push_pop_full();
      test_halt_drain();
      test_random();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
